// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Exports the round-10 key so a decrypt path can run its reverse key schedule.
module aes128_encrypt_core #(
    parameter bit DONE_HOLD  = 1'b1,
    parameter bit KEY_OUT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] initial_key,
    output logic         busy,
    output logic [127:0] ciphertext,
    output logic         ciphertext_valid,
    output logic [127:0] last_round_key
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0, so the reset state stays X-free).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = ginv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // SubBytes followed by ShiftRows; byte i sits at bits [127-8i -: 8], row = i%4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic         busy_q, busy_d;
    logic [127:0] ct_q, ct_d;
    logic         valid_q, valid_d;
    logic [127:0] lrk_q, lrk_d;
    logic [127:0] sb_sr_s;
    logic [127:0] rk_s;

    // SubBytes/ShiftRows and the key step are shared by ROUND and FINAL.
    always_comb begin
        sb_sr_s = sub_shift(state_q);
        rk_s    = next_key(key_q, rcon_of(rnd_q));
    end

    // Next-state and datapath selection for the round FSM.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        key_d   = key_q;
        busy_d  = busy_q;
        ct_d    = ct_q;
        valid_d = valid_q;
        lrk_d   = lrk_q;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    state_d = plaintext ^ initial_key;
                    key_d   = initial_key;
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    fsm_d   = S_ROUND;
                end else if (!DONE_HOLD) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            S_ROUND: begin
                state_d = mix_columns(sb_sr_s) ^ rk_s;
                key_d   = rk_s;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'd9) fsm_d = S_FINAL;
                else               fsm_d = S_ROUND;
            end
            S_FINAL: begin
                ct_d    = sb_sr_s ^ rk_s;
                if (KEY_OUT_EN) lrk_d = rk_s;
                else            lrk_d = 128'h0;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                rnd_d   = 4'd0;
                fsm_d   = S_IDLE;
            end
            default: begin
                fsm_d  = S_IDLE;
                rnd_d  = 4'd0;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= 4'd0;
            state_q <= 128'h0;
            key_q   <= 128'h0;
            busy_q  <= 1'b0;
            ct_q    <= 128'h0;
            valid_q <= 1'b0;
            lrk_q   <= 128'h0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            ct_q    <= ct_d;
            valid_q <= valid_d;
            lrk_q   <= lrk_d;
        end
    end

    assign busy             = busy_q;
    assign ciphertext       = ct_q;
    assign ciphertext_valid = valid_q;
    assign last_round_key   = lrk_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed-vector bench for aes128_encrypt_core using FIPS-197 App.B and App.C.1 vectors;
// a second instance covers the pulsed-valid / key-output-disabled configuration.
module tb_aes128_encrypt_core;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] L1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] L2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] pt, key;
    logic         busy_h, valid_h, busy_p, valid_p;
    logic [127:0] ct_h, lrk_h, ct_p, lrk_p;
    int           checks = 0;
    int           failures = 0;

    aes128_encrypt_core #(.DONE_HOLD(1'b1), .KEY_OUT_EN(1'b1)) dut_hold (
        .clk(clk), .reset_n(reset_n), .start(start), .plaintext(pt), .initial_key(key),
        .busy(busy_h), .ciphertext(ct_h), .ciphertext_valid(valid_h), .last_round_key(lrk_h)
    );

    aes128_encrypt_core #(.DONE_HOLD(1'b0), .KEY_OUT_EN(1'b0)) dut_pulse (
        .clk(clk), .reset_n(reset_n), .start(start), .plaintext(pt), .initial_key(key),
        .busy(busy_p), .ciphertext(ct_p), .ciphertext_valid(valid_p), .last_round_key(lrk_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, optionally pulse ignored starts at edges N+3 and N+9, check the result.
    task automatic run_block(input logic [127:0] p, input logic [127:0] k, input logic [127:0] ec,
                             input logic [127:0] el, input bit inject, input string tag);
        int cyc;
        int bcnt;
        pt = p; key = k; start = 1'b1;
        tick();
        start = 1'b0; pt = ~p; key = ~k;
        cyc  = 0;
        bcnt = busy_h ? 1 : 0;
        while (!valid_h && cyc < 30) begin
            if (inject && (cyc == 2 || cyc == 8)) begin
                start = 1'b1; pt = P2; key = K2;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (busy_h) bcnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"},   128'(cyc),  128'd10);
        chk({tag, "_busy_cyc"},  128'(bcnt), 128'd10);
        chk({tag, "_ct"},        ct_h,       ec);
        chk({tag, "_lrk"},       lrk_h,      el);
        chk({tag, "_ct_p"},      ct_p,       ec);
        chk({tag, "_valid_p"},   128'(valid_p), 128'd1);
        chk({tag, "_lrk_off"},   lrk_p,      128'h0);
        chk({tag, "_busy_end"},  128'(busy_h), 128'd0);
        tick();
        chk({tag, "_valid_hold"},  128'(valid_h), 128'd1);
        chk({tag, "_valid_pulse"}, 128'(valid_p), 128'd0);
        chk({tag, "_idle"},        128'(busy_h),  128'd0);
        chk({tag, "_ct_hold"},     ct_h,          ec);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; start = 1'b0; pt = 128'h0; key = 128'h0;
        #12;
        chk("rst_busy",  128'(busy_h),  128'd0);
        chk("rst_valid", 128'(valid_h), 128'd0);
        chk("rst_ct",    ct_h,          128'h0);
        chk("rst_lrk",   lrk_h,         128'h0);
        reset_n = 1'b1;
        tick();

        run_block(P1, K1, C1, L1, 1'b0, "t1");
        run_block(P2, K2, C2, L2, 1'b0, "t2");
        run_block(P1, K1, C1, L1, 1'b1, "t3");
        chk("t3_no_accept", 128'(busy_h), 128'd0);

        // Start held high: T2 then T1, accepts 11 cycles apart.
        pt = P2; key = K2; start = 1'b1;
        tick();
        pt = P1; key = K1;
        cyc = 0;
        while (!valid_h && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("t4a_latency", 128'(cyc), 128'd10);
        chk("t4a_ct",      ct_h,      C2);
        chk("t4a_valid_p", 128'(valid_p), 128'd1);
        tick();
        start = 1'b0;
        chk("t4_valid_drop", 128'(valid_h), 128'd0);
        chk("t4_busy_2nd",   128'(busy_h),  128'd1);
        chk("t4_ct_kept",    ct_h,          C2);
        chk("t4_pulse_low",  128'(valid_p), 128'd0);
        cyc = 0;
        while (!valid_h && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("t4b_latency", 128'(cyc), 128'd10);
        chk("t4b_ct",      ct_h,      C1);
        chk("t4b_lrk",     lrk_h,     L1);
        tick();

        // Asynchronous reset mid-operation clears everything at once.
        pt = P1; key = K1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_busy",  128'(busy_h),  128'd0);
        chk("t5_valid", 128'(valid_h), 128'd0);
        chk("t5_ct",    ct_h,          128'h0);
        chk("t5_lrk",   lrk_h,         128'h0);
        tick();
        chk("t5_held", ct_h, 128'h0);
        reset_n = 1'b1;
        tick();
        run_block(P2, K2, C2, L2, 1'b0, "t5r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
